// File: rtl/conv_pkg.sv
// Shared types and constants for the 3x3 convolution control path.
package conv_pkg;

  typedef enum logic [2:0] {
    IDLE,
    HDR,
    HDR_WAIT,
    MAC,
    DRAIN,
    WRITE,
    DONE
  } state_e;

  localparam int ADDR_W = 12;
  localparam int KERNEL = 3;
  localparam int TAPS   = 9;

  localparam logic [ADDR_W-1:0] HDR_ADDR = 12'd0;
  localparam logic [ADDR_W-1:0] IN_BASE  = 12'd1;

  // Row-major tap number, which is also the weight memory word address.
  function automatic logic [3:0] tapIndex(input logic [1:0] kr, input logic [1:0] kc);
    return 4'(kr) * 4'(KERNEL) + 4'(kc);
  endfunction

endpackage

// File: rtl/conv_addr_gen.sv
// Window/pixel counters for the convolution walk; emits registered input and
// weight read addresses plus the running output index and walk-end flags.
module conv_addr_gen
  import conv_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic [4:0]        dim_i,
  input  logic              hdrLoad_i,
  input  logic              start_i,
  input  logic              tapAdv_i,
  input  logic              pixAdv_i,
  output logic [ADDR_W-1:0] in_addr_o,
  output logic [ADDR_W-1:0] w_addr_o,
  output logic [ADDR_W-1:0] outIdx_o,
  output logic              firstTap_o,
  output logic              lastTap_o,
  output logic              lastPixel_o
);

  logic [4:0]        row_q, row_d, col_q, col_d;
  logic [1:0]        kr_q, kr_d, kc_q, kc_d;
  logic [ADDR_W-1:0] inAddr_q, inAddr_d, wAddr_q, wAddr_d;
  logic [4:0]        lastPos, outWidth;

  assign lastPos  = dim_i - 5'd3;
  assign outWidth = dim_i - 5'd2;

  // Addresses are computed from the next counter values so they appear in the
  // same cycle the FSM presents the corresponding tap.
  always_comb begin
    row_d    = row_q;
    col_d    = col_q;
    kr_d     = kr_q;
    kc_d     = kc_q;
    inAddr_d = inAddr_q;
    wAddr_d  = wAddr_q;

    if (start_i) begin
      row_d = '0;
      col_d = '0;
      kr_d  = '0;
      kc_d  = '0;
    end else if (tapAdv_i) begin
      if (kc_q == 2'(KERNEL - 1)) begin
        kc_d = '0;
        kr_d = kr_q + 2'd1;
      end else begin
        kc_d = kc_q + 2'd1;
      end
    end else if (pixAdv_i) begin
      kr_d = '0;
      kc_d = '0;
      if (col_q == lastPos) begin
        col_d = '0;
        row_d = row_q + 5'd1;
      end else begin
        col_d = col_q + 5'd1;
      end
    end

    if (hdrLoad_i) begin
      inAddr_d = HDR_ADDR;
      wAddr_d  = '0;
    end else if (start_i || tapAdv_i || pixAdv_i) begin
      inAddr_d = IN_BASE + (ADDR_W'(row_d) + ADDR_W'(kr_d)) * ADDR_W'(dim_i)
                 + ADDR_W'(col_d) + ADDR_W'(kc_d);
      wAddr_d  = ADDR_W'(tapIndex(kr_d, kc_d));
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      row_q    <= '0;
      col_q    <= '0;
      kr_q     <= '0;
      kc_q     <= '0;
      inAddr_q <= '0;
      wAddr_q  <= '0;
    end else begin
      row_q    <= row_d;
      col_q    <= col_d;
      kr_q     <= kr_d;
      kc_q     <= kc_d;
      inAddr_q <= inAddr_d;
      wAddr_q  <= wAddr_d;
    end
  end

  assign in_addr_o   = inAddr_q;
  assign w_addr_o    = wAddr_q;
  assign outIdx_o    = ADDR_W'(row_q) * ADDR_W'(outWidth) + ADDR_W'(col_q);
  assign firstTap_o  = (kr_q == 2'd0) && (kc_q == 2'd0);
  assign lastTap_o   = tapIndex(kr_q, kc_q) == 4'(TAPS - 1);
  assign lastPixel_o = (row_q == lastPos) && (col_q == lastPos);

endmodule

// File: rtl/conv_sequencer.sv
// Run/busy control FSM for the 3x3 convolution datapath: header fetch, per-pixel
// MAC sequencing and result write. CONV_PERF_EN adds the perf_cycles counter.
module conv_sequencer
  import conv_pkg::*;
#(
  parameter int                MAX_DIM  = 16,
  parameter logic [ADDR_W-1:0] OUT_BASE = 12'h200
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              run,
  output logic              busy,
  input  logic [15:0]       hdr_data,
  output logic [ADDR_W-1:0] in_addr,
  output logic [ADDR_W-1:0] w_addr,
  output logic              mac_clr,
  output logic              mac_en,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic              err
`ifdef CONV_PERF_EN
  ,
  output logic [15:0]       perf_cycles
`endif
);

  localparam logic [5:0] MaxDimW = 6'(MAX_DIM);

  state_e            state_q, state_d;
  logic [4:0]        dim_q;
  logic              busy_q, macEn_q, macClr_q, wrEn_q, err_q;
  logic [ADDR_W-1:0] wrAddr_q;

  logic [4:0]        hdrDim;
  logic              hdrTooBig, hdrBad, runAccept;
  logic              agStart, agTapAdv, agPixAdv, agHdrLoad;
  logic [ADDR_W-1:0] outIdx;
  logic              firstTap, lastTap, lastPixel;
  logic              unusedHdrBits;

  assign hdrDim        = hdr_data[4:0];
  assign unusedHdrBits = ^hdr_data[15:5];
  assign hdrTooBig     = {1'b0, hdrDim} > MaxDimW;
  assign hdrBad        = hdrTooBig || (hdrDim < 5'd3);
  assign runAccept     = (state_q == IDLE) && run;

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:     if (run) state_d = HDR;
      HDR:      state_d = HDR_WAIT;
      HDR_WAIT: state_d = hdrBad ? DONE : MAC;
      MAC:      if (lastTap) state_d = DRAIN;
      DRAIN:    state_d = WRITE;
      WRITE:    state_d = lastPixel ? DONE : MAC;
      DONE:     state_d = IDLE;
      default:  state_d = IDLE;
    endcase
  end

  assign agHdrLoad = (state_d == HDR);
  assign agStart   = (state_q == HDR_WAIT) && (state_d == MAC);
  assign agTapAdv  = (state_q == MAC) && !lastTap;
  assign agPixAdv  = (state_q == WRITE) && (state_d == MAC);

  conv_addr_gen u_addr_gen (
    .clk        (clk),
    .reset      (reset),
    .dim_i      (dim_q),
    .hdrLoad_i  (agHdrLoad),
    .start_i    (agStart),
    .tapAdv_i   (agTapAdv),
    .pixAdv_i   (agPixAdv),
    .in_addr_o  (in_addr),
    .w_addr_o   (w_addr),
    .outIdx_o   (outIdx),
    .firstTap_o (firstTap),
    .lastTap_o  (lastTap),
    .lastPixel_o(lastPixel)
  );

  // MAC strobes trail the read addresses by one cycle to match SRAM latency.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      dim_q    <= '0;
      busy_q   <= 1'b0;
      macEn_q  <= 1'b0;
      macClr_q <= 1'b0;
      wrEn_q   <= 1'b0;
      wrAddr_q <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      busy_q   <= (state_d != IDLE);
      macEn_q  <= (state_q == MAC);
      macClr_q <= (state_q == MAC) && firstTap;
      wrEn_q   <= (state_d == WRITE);
      if (state_d == WRITE) wrAddr_q <= OUT_BASE + outIdx;
      if (state_q == HDR_WAIT) dim_q <= hdrDim;
      if (runAccept) err_q <= 1'b0;
      else if ((state_q == HDR_WAIT) && hdrTooBig) err_q <= 1'b1;
    end
  end

  assign busy    = busy_q;
  assign mac_en  = macEn_q;
  assign mac_clr = macClr_q;
  assign wr_en   = wrEn_q;
  assign wr_addr = wrAddr_q;
  assign err     = err_q;

`ifdef CONV_PERF_EN
  logic [15:0] perf_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      perf_q <= '0;
    end else if (runAccept) begin
      perf_q <= '0;
    end else if (busy_q && (perf_q != 16'hFFFF)) begin
      perf_q <= perf_q + 16'd1;
    end
  end

  assign perf_cycles = perf_q;
`endif

endmodule

// File: tb/tb_conv_sequencer.sv
// Directed self-checking bench for conv_sequencer; strobe/address timing is
// predicted per busy cycle from the header dimension.
module tb_conv_sequencer;

  logic        clk = 1'b0;
  logic        reset, run;
  logic [15:0] hdr_data;
  logic        busy, mac_clr, mac_en, wr_en, err;
  logic [11:0] in_addr, w_addr, wr_addr;
`ifdef CONV_PERF_EN
  logic [15:0] perf_cycles;
`endif

  logic [15:0] hdrVal;
  int          compared   = 0;
  int          mismatched = 0;

  conv_sequencer dut (
    .clk        (clk),
    .reset      (reset),
    .run        (run),
    .busy       (busy),
    .hdr_data   (hdr_data),
    .in_addr    (in_addr),
    .w_addr     (w_addr),
    .mac_clr    (mac_clr),
    .mac_en     (mac_en),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .err        (err)
`ifdef CONV_PERF_EN
    ,
    .perf_cycles(perf_cycles)
`endif
  );

  always #5 clk = ~clk;

  // One-cycle-latency SRAM: header at word 0, filler elsewhere.
  always @(posedge clk) hdr_data <= (in_addr == 12'h000) ? hdrVal : 16'h00E9;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    compared++;
    if (observed !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  // Pulses run, then walks every busy cycle comparing strobes/addresses to the
  // expected schedule: HDR, HDR_WAIT, then 11 cycles per pixel, then DONE.
  task automatic applyStimulus(input logic [15:0] hdr, input int pulseAt, input int resetAt,
                               output int busyCycles, output int writes,
                               output int modelErr, output logic errEnd);
    int   n, pix, idx, j, pos, p, rr, cc, kr, kc;
    logic expEn, expClr, expWr, expErr;
    n          = int'(hdr[4:0]);
    pix        = (n >= 3 && n <= 16) ? (n - 2) * (n - 2) : 0;
    busyCycles = 0;
    writes     = 0;
    modelErr   = 0;
    errEnd     = 1'b0;
    idx        = 1;
    hdrVal     = hdr;
    @(negedge clk) run = 1'b1;
    @(negedge clk) run = 1'b0;
    while (busy === 1'b1 && idx <= 4000) begin
      busyCycles++;
      run    = (idx == pulseAt);
      expEn  = 1'b0;
      expClr = 1'b0;
      expWr  = 1'b0;
      expErr = (idx >= 3) && (n > 16);
      if (idx == 1 && in_addr !== 12'h000) modelErr++;
      if (pix > 0 && idx >= 3 && (idx - 3) < 11 * pix) begin
        j      = idx - 3;
        pos    = j % 11;
        p      = j / 11;
        expEn  = (pos >= 1 && pos <= 9);
        expClr = (pos == 1);
        expWr  = (pos == 10);
        if (pos <= 8) begin
          rr = p / (n - 2);
          cc = p % (n - 2);
          kr = pos / 3;
          kc = pos % 3;
          if (in_addr !== 12'(1 + (rr + kr) * n + cc + kc) || w_addr !== 12'(pos)) modelErr++;
        end
        if (expWr && wr_addr !== 12'(32'h200 + p)) modelErr++;
      end
      if (mac_en !== expEn || mac_clr !== expClr || wr_en !== expWr || err !== expErr)
        modelErr++;
      if (wr_en === 1'b1) writes++;
      if (idx == resetAt) begin
        reset = 1'b1;
        @(negedge clk);
        checkOutput("rstBusy", 32'(busy), 32'd0);
        checkOutput("rstStrobes", 32'({mac_en, mac_clr, wr_en}), 32'd0);
        checkOutput("rstAddr", 32'({in_addr, w_addr}), 32'd0);
        reset = 1'b0;
        return;
      end
      @(negedge clk);
      idx++;
    end
    run = 1'b0;
    checkOutput("runBounded", 32'(idx <= 4000), 32'd1);
    checkOutput("idleStrobes", 32'({mac_en, mac_clr, wr_en}), 32'd0);
    errEnd = err;
    repeat (3) begin
      @(negedge clk);
      if (busy !== 1'b0) modelErr++;
    end
  endtask

  initial begin
    #300000;
    $display("[TB] FAIL watchdog: observed timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int   bc, wc, me, gap, guard;
    logic ee;
    reset  = 1'b1;
    run    = 1'b0;
    hdrVal = 16'h0000;
    repeat (3) @(negedge clk);
    checkOutput("rstValBusy", 32'(busy), 32'd0);
    checkOutput("rstValStrb", 32'({mac_en, mac_clr, wr_en, err}), 32'd0);
    checkOutput("rstValAddr", 32'({in_addr, w_addr}), 32'd0);
    checkOutput("rstValWrAddr", 32'(wr_addr), 32'd0);
    reset = 1'b0;
    @(negedge clk);
    checkOutput("idleNoRun", 32'(busy), 32'd0);

    $display("[TB] N=4 basic run");
    applyStimulus(16'hA404, 0, 0, bc, wc, me, ee);
    checkOutput("n4Busy", bc, 47);
    checkOutput("n4Writes", wc, 4);
    checkOutput("n4Model", me, 0);
    checkOutput("n4Err", 32'(ee), 32'd0);
`ifdef CONV_PERF_EN
    checkOutput("perfDone", 32'(perf_cycles), 32'd47);
    repeat (10) @(negedge clk);
    checkOutput("perfHold", 32'(perf_cycles), 32'd47);
`endif

    $display("[TB] N=2 header");
    applyStimulus(16'h0002, 0, 0, bc, wc, me, ee);
    checkOutput("n2Busy", bc, 3);
    checkOutput("n2Writes", wc, 0);
    checkOutput("n2Model", me, 0);
    checkOutput("n2Err", 32'(ee), 32'd0);

    $display("[TB] N=17 header");
    applyStimulus(16'h0011, 0, 0, bc, wc, me, ee);
    checkOutput("n17Busy", bc, 3);
    checkOutput("n17Writes", wc, 0);
    checkOutput("n17Model", me, 0);
    checkOutput("n17Err", 32'(ee), 32'd1);

    $display("[TB] N=3 after error");
    applyStimulus(16'h0003, 0, 0, bc, wc, me, ee);
    checkOutput("n3Busy", bc, 14);
    checkOutput("n3Writes", wc, 1);
    checkOutput("n3Model", me, 0);
    checkOutput("n3Err", 32'(ee), 32'd0);

    $display("[TB] N=4 with run pulsed during MAC");
    applyStimulus(16'h0004, 6, 0, bc, wc, me, ee);
    checkOutput("pulseBusy", bc, 47);
    checkOutput("pulseWrites", wc, 4);
    checkOutput("pulseModel", me, 0);

    $display("[TB] N=16 largest legal image");
    applyStimulus(16'h0010, 0, 0, bc, wc, me, ee);
    checkOutput("n16Busy", bc, 2159);
    checkOutput("n16Writes", wc, 196);
    checkOutput("n16Model", me, 0);

    $display("[TB] N=5 reset during WRITE of pixel 2");
    applyStimulus(16'h0005, 0, 35, bc, wc, me, ee);
    checkOutput("cutModel", me, 0);
    checkOutput("cutBusy", bc, 35);
    @(negedge clk);
    applyStimulus(16'h0005, 0, 0, bc, wc, me, ee);
    checkOutput("n5Busy", bc, 102);
    checkOutput("n5Writes", wc, 9);
    checkOutput("n5Model", me, 0);

    $display("[TB] run held high back-to-back");
    hdrVal = 16'h0003;
    @(negedge clk) run = 1'b1;
    guard = 0;
    while (busy !== 1'b1 && guard < 5) begin
      @(negedge clk);
      guard++;
    end
    bc = 0;
    while (busy === 1'b1 && bc < 100) begin
      bc++;
      @(negedge clk);
    end
    gap = 0;
    while (busy !== 1'b1 && gap < 5) begin
      gap++;
      @(negedge clk);
    end
    run = 1'b0;
    checkOutput("b2bBusy", bc, 14);
    checkOutput("b2bGap", gap, 1);
    guard = 0;
    while (busy === 1'b1 && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    checkOutput("b2bSecondLen", guard, 14);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
